// File: rtl/cross_bar_pkg.sv
// Shared constants and types for the cross_bar request/acknowledge crossbar.
package cross_bar_pkg;

  localparam int unsigned MASTER_N = 4;
  localparam int unsigned SLAVE_N  = 4;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASTER_W = $clog2(MASTER_N);
  localparam int unsigned SLAVE_W  = $clog2(SLAVE_N);

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [MASTER_W-1:0] midx_t;
  typedef logic [SLAVE_W-1:0]  sidx_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } port_state_e;

  // Slave select lives in the top address bits.
  function automatic sidx_t addr2slave(input addr_t a);
    return a[ADDR_W-1 -: SLAVE_W];
  endfunction

endpackage

// File: rtl/cross_bar_if.sv
// Request/acknowledge bus bundle; N lanes, one per master or per slave.
interface cross_bar_if
  import cross_bar_pkg::*;
#(
  parameter int unsigned N = 4
);

  logic  [N-1:0] req;
  addr_t [N-1:0] addr;
  logic  [N-1:0] cmd;
  data_t [N-1:0] wdata;
  logic  [N-1:0] ack;
  data_t [N-1:0] rdata;

  modport master (output req, addr, cmd, wdata, input  ack, rdata);
  modport slave  (input  req, addr, cmd, wdata, output ack, rdata);

endinterface

// File: rtl/cross_bar_slave_port.sv
// One slave port: eligibility, arbitration and IDLE/BUSY request FSM.
// CROSS_BAR_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module cross_bar_slave_port
  import cross_bar_pkg::*;
#(
  parameter int unsigned SLAVE_IDX = 0
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic  [MASTER_N-1:0]  req_i,
  input  sidx_t [MASTER_N-1:0]  tgt_i,
  input  logic  [MASTER_N-1:0]  block_i,
  input  addr_t [MASTER_N-1:0]  addr_i,
  input  logic  [MASTER_N-1:0]  cmd_i,
  input  data_t [MASTER_N-1:0]  wdata_i,
  input  logic                  slave_ack_i,
  input  data_t                 slave_rdata_i,
  output logic                  slave_req_o,
  output addr_t                 slave_addr_o,
  output logic                  slave_cmd_o,
  output data_t                 slave_wdata_o,
  output logic  [MASTER_N-1:0]  ack_o,
  output data_t                 rdata_o
);

  port_state_e         state_q, state_d;
  logic [MASTER_N-1:0] elig;
  logic                found;
  midx_t               win, cand;
  midx_t               owner_q, owner_d;
  addr_t               addr_q, addr_d;
  logic                cmd_q, cmd_d;
  data_t               wdata_q, wdata_d;
  logic [MASTER_N-1:0] ack_q, ack_d;
  data_t               rdata_q, rdata_d;
`ifndef CROSS_BAR_FIXED_PRIO_EN
  midx_t               ptr_q, ptr_d;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < MASTER_N; i++) begin
      elig[i] = req_i[i] & ~block_i[i] & (tgt_i[i] == SLAVE_W'(SLAVE_IDX));
    end
  end

  // Arbiter: scan from the priority origin, first eligible master wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < MASTER_N; i++) begin
`ifdef CROSS_BAR_FIXED_PRIO_EN
      cand = MASTER_W'(i);
`else
      cand = MASTER_W'((32'(ptr_q) + 32'(i)) % MASTER_N);
`endif
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found)       state_d = S_BUSY;
      S_BUSY:  if (slave_ack_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
`ifndef CROSS_BAR_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    if (state_q == S_IDLE && found) begin
      owner_d = win;
      addr_d  = addr_i[win];
      cmd_d   = cmd_i[win];
      wdata_d = wdata_i[win];
`ifndef CROSS_BAR_FIXED_PRIO_EN
      ptr_d   = MASTER_W'((32'(win) + 32'd1) % MASTER_N);
`endif
    end
    if (state_q == S_BUSY && slave_ack_i) begin
      ack_d[owner_q] = 1'b1;
      rdata_d        = slave_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (aresetn) begin
      owner_q <= '0;
      addr_q  <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
`ifndef CROSS_BAR_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifndef CROSS_BAR_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign slave_req_o   = (state_q == S_BUSY);
  assign slave_addr_o  = addr_q;
  assign slave_cmd_o   = cmd_q;
  assign slave_wdata_o = wdata_q;
  assign ack_o         = ack_q;
  assign rdata_o       = rdata_q;

endmodule

// File: rtl/cross_bar.sv
// MASTER_N x SLAVE_N request/ack crossbar: decode, turnaround, response merge.
// Build with CROSS_BAR_FIXED_PRIO_EN for fixed-priority arbitration.
module cross_bar
  import cross_bar_pkg::*;
(
  input  logic          clk,
  input  logic          aresetn,
  cross_bar_if.slave    m_if,
  cross_bar_if.master   s_if
);

  sidx_t [MASTER_N-1:0]                tgt;
  logic  [MASTER_N-1:0]                tat_q, block;
  logic  [SLAVE_N-1:0][MASTER_N-1:0]   p_ack;
  data_t [SLAVE_N-1:0]                 p_rdata;
  logic  [SLAVE_N-1:0]                 s_req, s_cmd;
  addr_t [SLAVE_N-1:0]                 s_addr;
  data_t [SLAVE_N-1:0]                 s_wdata;
  logic  [MASTER_N-1:0]                m_ack;
  data_t [MASTER_N-1:0]                m_rdata;

  always_comb begin
    tgt = '0;
    for (int m = 0; m < MASTER_N; m++) tgt[m] = addr2slave(m_if.addr[m]);
  end

  // A master's req is ignored in its ack cycle and the cycle after.
  assign block = m_ack | tat_q;

  always_ff @(posedge clk) begin
    if (aresetn) tat_q <= '0;
    else         tat_q <= m_ack;
  end

  for (genvar s = 0; s < SLAVE_N; s++) begin : g_port
    cross_bar_slave_port #(.SLAVE_IDX(s)) u_port (
      .clk           (clk),
      .aresetn       (aresetn),
      .req_i         (m_if.req),
      .tgt_i         (tgt),
      .block_i       (block),
      .addr_i        (m_if.addr),
      .cmd_i         (m_if.cmd),
      .wdata_i       (m_if.wdata),
      .slave_ack_i   (s_if.ack[s]),
      .slave_rdata_i (s_if.rdata[s]),
      .slave_req_o   (s_req[s]),
      .slave_addr_o  (s_addr[s]),
      .slave_cmd_o   (s_cmd[s]),
      .slave_wdata_o (s_wdata[s]),
      .ack_o         (p_ack[s]),
      .rdata_o       (p_rdata[s])
    );
  end

  always_comb begin
    m_ack   = '0;
    m_rdata = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      for (int m = 0; m < MASTER_N; m++) begin
        if (p_ack[s][m]) begin
          m_ack[m]   = 1'b1;
          m_rdata[m] = m_rdata[m] | p_rdata[s];
        end
      end
    end
  end

  assign m_if.ack    = m_ack;
  assign m_if.rdata  = m_rdata;
  assign s_if.req    = s_req;
  assign s_if.addr   = s_addr;
  assign s_if.cmd    = s_cmd;
  assign s_if.wdata  = s_wdata;

endmodule

// File: tb/tb_cross_bar.sv
// Directed scoreboard bench for cross_bar with memory-model slaves.
module tb_cross_bar;
  import cross_bar_pkg::*;

  typedef struct { int m; data_t d; } exp_t;
  typedef struct { int s; addr_t a; } log_t;

  logic clk;
  logic aresetn;
  int   vectors = 0;
  int   errs    = 0;

  cross_bar_if #(.N(MASTER_N)) mif ();
  cross_bar_if #(.N(SLAVE_N))  sif ();

  cross_bar u_dut (
    .clk     (clk),
    .aresetn (aresetn),
    .m_if    (mif),
    .s_if    (sif)
  );

  exp_t  sb[$];
  log_t  slog[$];
  data_t mem [addr_t];
  int    rem[MASTER_N];
  int    hold[MASTER_N];
  int    drop_cnt[MASTER_N];
  int    cnt[SLAVE_N];
  int    lat[SLAVE_N] = '{1, 2, 4, 3};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory slaves: ack after lat[s] cycles; writes return 0x600d0000|s, unwritten reads return ~addr.
  initial begin
    logic prev;
    addr_t a;
    sif.ack   = '0;
    sif.rdata = '0;
    for (int s = 0; s < SLAVE_N; s++) cnt[s] = 0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < SLAVE_N; s++) begin
        prev       = sif.ack[s];
        sif.ack[s] = 1'b0;
        if (aresetn) begin
          cnt[s] = 0;
        end else if (sif.req[s] === 1'b1 && !prev) begin
          if (cnt[s] == lat[s] - 1) begin
            cnt[s]     = 0;
            a          = sif.addr[s];
            sif.ack[s] = 1'b1;
            if (sif.cmd[s]) begin
              mem[a]       = sif.wdata[s];
              sif.rdata[s] = 32'h600d_0000 | DATA_W'(s);
            end else begin
              sif.rdata[s] = mem.exists(a) ? mem[a] : ~a;
            end
            slog.push_back('{s: s, a: a});
          end else begin
            cnt[s]++;
          end
        end
      end
    end
  end

  // Monitor: every master_ack pops the oldest expectation for that master.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < MASTER_N; m++) begin
        if (mif.ack[m] === 1'b1) begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].m == m) idx = i;
          vectors++;
          if (idx < 0) begin
            errs++;
            $display("FAIL ack_m%0d: unexpected ack, rdata %h expected no ack", m, mif.rdata[m]);
          end else begin
            if (mif.rdata[m] !== sb[idx].d) begin
              errs++;
              $display("FAIL rdata_m%0d: got %h expected %h", m, mif.rdata[m], sb[idx].d);
            end
            sb.delete(idx);
          end
        end
      end
    end
  end

  task automatic issue(input int m, input addr_t a, input logic c, input data_t wd, input data_t exp);
    exp_t e;
    mif.req[m]   = 1'b1;
    mif.addr[m]  = a;
    mif.cmd[m]   = c;
    mif.wdata[m] = wd;
    e.m = m;
    e.d = exp;
    sb.push_back(e);
    rem[m]++;
  endtask

  // Hold each master's req until its expected acks arrive (plus optional hold-over), then drain.
  task automatic run(input string nm, input int max_cyc);
    int n;
    n = 0;
    while (mif.req != '0 && n < max_cyc) begin
      @(negedge clk);
      n++;
      for (int m = 0; m < MASTER_N; m++) begin
        if (drop_cnt[m] > 0) begin
          drop_cnt[m]--;
          if (drop_cnt[m] == 0) mif.req[m] = 1'b0;
        end
        if (mif.ack[m] === 1'b1 && rem[m] > 0) begin
          rem[m]--;
          if (rem[m] == 0) begin
            if (hold[m] == 0) mif.req[m] = 1'b0;
            else              drop_cnt[m] = hold[m];
          end
        end
      end
    end
    if (n >= max_cyc) begin
      vectors++;
      errs++;
      $display("FAIL %s_timeout: req still %b after %0d cycles, expected all acked", nm, mif.req, n);
    end
    repeat (6) @(negedge clk);
    check({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  function automatic int log_cnt(input int s);
    int c;
    c = 0;
    foreach (slog[i]) if (slog[i].s == s) c++;
    return c;
  endfunction

  task automatic chk_log(input int s, input int k, input addr_t exp, input string nm);
    int    seen;
    addr_t got;
    seen = 0;
    got  = '1;
    foreach (slog[i]) begin
      if (slog[i].s == s) begin
        if (seen == k) got = slog[i].a;
        seen++;
      end
    end
    check(nm, 64'(got), 64'(exp));
  endtask

  initial begin
    int n;
    aresetn   = 1'b1;
    mif.req   = '0;
    mif.addr  = '0;
    mif.cmd   = '0;
    mif.wdata = '0;
    for (int m = 0; m < MASTER_N; m++) begin
      rem[m] = 0; hold[m] = 0; drop_cnt[m] = 0;
    end
    repeat (20) @(negedge clk);
    check("rst_slave_req", 64'(sif.req), 64'd0);
    check("rst_master_ack", 64'(mif.ack), 64'd0);
    check("rst_slave_addr3", 64'(sif.addr[3]), 64'd0);
    aresetn = 1'b0;
    @(negedge clk);

    // T1: two writes contend for S3, a read to S2 runs concurrently.
    issue(0, 32'hdead_beef, 1'b1, 32'hdead_c0de, 32'h600d_0003);
    issue(1, 32'hd200_0004, 1'b1, 32'h0f0f_0f0f, 32'h600d_0003);
    issue(2, 32'ha000_0000, 1'b0, 32'h0,         32'h5fff_ffff);
    run("t1", 200);
    chk_log(3, 0, 32'hdead_beef, "t1_s3_grant0");
    chk_log(3, 1, 32'hd200_0004, "t1_s3_grant1");

    // T2: read back.
    issue(0, 32'hdead_beef, 1'b0, 32'h0, 32'hdead_c0de);
    issue(1, 32'hd200_0004, 1'b0, 32'h0, 32'h0f0f_0f0f);
    run("t2", 200);

    // T3: all masters hammer S0; M0 served twice.
    issue(0, 32'h0000_0100, 1'b0, 32'h0, 32'hffff_feff);
    issue(0, 32'h0000_0100, 1'b0, 32'h0, 32'hffff_feff);
    issue(1, 32'h0000_0104, 1'b0, 32'h0, 32'hffff_fefb);
    issue(2, 32'h0000_0108, 1'b0, 32'h0, 32'hffff_fef7);
    issue(3, 32'h0000_010c, 1'b0, 32'h0, 32'hffff_fef3);
    run("t3", 300);
`ifdef CROSS_BAR_FIXED_PRIO_EN
    chk_log(0, 0, 32'h0000_0100, "t3_s0_grant0");
    chk_log(0, 1, 32'h0000_0104, "t3_s0_grant1");
    chk_log(0, 2, 32'h0000_0100, "t3_s0_grant2");
    chk_log(0, 3, 32'h0000_0108, "t3_s0_grant3");
    chk_log(0, 4, 32'h0000_010c, "t3_s0_grant4");
`else
    chk_log(0, 0, 32'h0000_0100, "t3_s0_grant0");
    chk_log(0, 1, 32'h0000_0104, "t3_s0_grant1");
    chk_log(0, 2, 32'h0000_0108, "t3_s0_grant2");
    chk_log(0, 3, 32'h0000_010c, "t3_s0_grant3");
    chk_log(0, 4, 32'h0000_0100, "t3_s0_grant4");
`endif
    check("t3_s0_count", 64'(log_cnt(0)), 64'd5);

    // T4: M0 holds req past its ack; only one transfer may reach S1.
    hold[0] = 2;
    issue(0, 32'h4000_0000, 1'b0, 32'h0, 32'hbfff_ffff);
    @(posedge clk);
    #1;
    check("t4_req_latency", 64'(sif.req[1]), 64'd1);
    run("t4", 200);
    hold[0] = 0;
    check("t4_s1_count", 64'(log_cnt(1)), 64'd1);

    // T6: M0 and M3 contend for S1 after M0 was its last winner.
    issue(0, 32'h4000_0020, 1'b0, 32'h0, 32'hbfff_ffdf);
    issue(3, 32'h4000_0030, 1'b0, 32'h0, 32'hbfff_ffcf);
    run("t6", 200);
`ifdef CROSS_BAR_FIXED_PRIO_EN
    chk_log(1, 1, 32'h4000_0020, "t6_s1_grant0");
    chk_log(1, 2, 32'h4000_0030, "t6_s1_grant1");
`else
    chk_log(1, 1, 32'h4000_0030, "t6_s1_grant0");
    chk_log(1, 2, 32'h4000_0020, "t6_s1_grant1");
`endif

    // T5: reset while S2 is busy; the aborted read must not ack, the retry must.
    issue(2, 32'ha000_0010, 1'b0, 32'h0, 32'h5fff_ffef);
    n = 0;
    while (sif.req[2] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_s2_busy", 64'(sif.req[2]), 64'd1);
    aresetn = 1'b1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].m == 2) begin
        sb.delete(i);
        break;
      end
    end
    rem[2] = 0;
    @(posedge clk);
    #1;
    check("t5_rst_slave_req", 64'(sif.req), 64'd0);
    check("t5_rst_master_ack", 64'(mif.ack), 64'd0);
    check("t5_rst_slave_addr2", 64'(sif.addr[2]), 64'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b0;
    sb.push_back('{m: 2, d: 32'h5fff_ffef});
    rem[2] = 1;
    run("t5", 200);
    check("t5_s2_count", 64'(log_cnt(2)), 64'd2);
    chk_log(2, 1, 32'ha000_0010, "t5_s2_retry");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
